bp_chip_wormhole_link_arbiter: RTL and testbench
================================================

// Module: bp_chip_wormhole_link_arbiter
//
// PURPOSE
// - Shares one ready&valid link channel between num_in_p wormhole flit sources.
//   Example: the cmd and resp streams that must share a single ct_fifo channel
//   into the chip IO complex (prev/next).
// - Round-robin arbitration, decided per packet.
// - Once a header flit wins, the grant stays locked to that source until the
//   last body flit has gone out. Packets are never interleaved.
// - Zero-latency pass-through datapath. No storage.
//
// PARAMETERS
// - num_in_p      default 2   number of requesting sources (>=2)
// - flit_width_p  default 64  flit width in bits (link_width_gp payload)
// - len_width_p   default 4   width of the header len field (number of body flits)
// - len_offset_p  default 0   LSB position of len in the header flit
//
// PORTS
// - clk_i    in   1                        single clock (router/mem clock domain)
// - reset_i  in   1                        synchronous, active-high reset
// - v_i      in   num_in_p                 per-source flit valid
// - data_i   in   num_in_p*flit_width_p    per-source flit; source k at [k*flit_width_p+:flit_width_p]
// - yumi_o   out  num_in_p                 per-source flit consumed this cycle
// - v_o      out  1                        merged flit valid
// - data_o   out  flit_width_p             merged flit
// - ready_i  in   1                        downstream ready (ready&valid handshake)
// - grant_o  out  num_in_p                 one-hot current owner/selection; 0 when none
// - busy_o   out  1                        1 while locked mid-packet
//
// BEHAVIOUR
// Reset (sync, reset_i=1 at posedge):
// - state=IDLE, cnt_r=0, last_r=num_in_p-1 (source 0 has first priority).
// - While reset_i=1: v_o=0, yumi_o=0, grant_o=0, busy_o=0, data_o don't-care.
// Handshake:
// - A transfer occurs when v_o & ready_i.
// - yumi_o[k] = transfer & (sel==k). At most one bit is set.
// - v_o/data_o never depend combinationally on ready_i.
// - yumi_o depends on ready_i.
// State IDLE:
// - sel = first k with v_i[k]=1, searching from last_r+1 upward, wrapping modulo num_in_p.
// - v_o = |v_i. data_o = data_i[sel]. grant_o = onehot(sel) if |v_i, else 0.
// - If there is no transfer, the selection is not registered. It may change next cycle
//   if v_i changes; last_r is unchanged.
// - On a header transfer with len = data_o[len_offset_p+:len_width_p]:
//   - len==0: stay IDLE, last_r<=sel (single-flit packet).
//   - len!=0: go to LOCKED, owner_r<=sel, cnt_r<=len.
// State LOCKED:
// - sel=owner_r. v_o=v_i[owner_r]. data_o=data_i[owner_r]. grant_o=onehot(owner_r). busy_o=1.
// - Other sources get yumi_o=0, whatever their v_i.
// - Each transfer: cnt_r<=cnt_r-1.
// - Transfer with cnt_r==1: go to IDLE, last_r<=owner_r, cnt_r<=0.
// - If the owner drops v_i mid-packet: v_o=0, stay LOCKED, and all other sources stall.
// Boundaries:
// - len=2^len_width_p-1 gives the maximum packet; cnt_r must not wrap.
// - All sources valid every cycle: grants rotate 0,1,..,num_in_p-1,0 per packet.
// - ready_i held low: the IDLE selection may shift among valid sources, but no transfer
//   happens and no state changes.
// - reset_i asserted mid-packet: abandon the packet and return to IDLE as above.
//   Remaining body flits of that packet are later treated as headers; recovery is the
//   upstream reset's responsibility.
// - Back-to-back packets: in the cycle after a tail, IDLE arbitration is fully
//   combinational, so a new header can transfer immediately (no bubble).
// - Assertion (sim only): $onehot0(yumi_o), and yumi_o implies v_i for that bit.
//
// TESTING
// - Reset release, only v_i[1]=1, header len=0, ready_i=1:
//   -> same cycle v_o=1, yumi_o=2'b10, grant_o=2'b10, busy_o=0; last_r=1.
// - Both sources valid continuously, 1-flit packets, ready_i=1 for 6 cycles:
//   -> grant_o sequence 01,10,01,10,01,10.
// - Src0 header len=3 then 3 body flits, src1 valid throughout:
//   -> 4 src0 transfers with busy_o=1 after the header, then src1 granted on the next cycle.
// - Owner src0 drops v_i for 2 cycles mid-packet while src1 is valid:
//   -> v_o=0, yumi_o=0 for those cycles, still LOCKED, resumes src0 body.
// - ready_i=0 for 5 cycles with a header pending:
//   -> v_o=1, data stable when v_i/data_i are stable, yumi_o=0, state unchanged.
// - Header len=15 (len_width_p=4), reset_i pulsed after 7 body flits:
//   -> next cycle busy_o=0, grant_o=0, and source 0 has priority again.

Source files
------------

// File: rtl/bp_chip_wormhole_link_arbiter_if.sv
// Link bundle between wormhole flit sources and the shared downstream channel.
// The slave modport is the arbiter's view; the master modport drives sources and ready.
interface bp_chip_wormhole_link_arbiter_if #(
    parameter int num_in_p     = 2,
    parameter int flit_width_p = 64
);
    logic [num_in_p-1:0]              v_i;
    logic [num_in_p*flit_width_p-1:0] data_i;
    logic [num_in_p-1:0]              yumi_o;
    logic                             v_o;
    logic [flit_width_p-1:0]          data_o;
    logic                             ready_i;
    logic [num_in_p-1:0]              grant_o;
    logic                             busy_o;

    modport master (
        output v_i, data_i, ready_i,
        input  yumi_o, v_o, data_o, grant_o, busy_o
    );

    modport slave (
        input  v_i, data_i, ready_i,
        output yumi_o, v_o, data_o, grant_o, busy_o
    );
endinterface

// File: rtl/bp_chip_wormhole_link_arbiter.sv
// Round-robin, packet-locked merge of num_in_p wormhole flit sources onto one link.
// Zero latency: flits pass straight through, nothing is stored.
// Backpressure: ready_i only gates yumi_o and state updates; v_o/data_o never see it.
module bp_chip_wormhole_link_arbiter #(
    parameter int num_in_p     = 2,
    parameter int flit_width_p = 64,
    parameter int len_width_p  = 4,
    parameter int len_offset_p = 0
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    bp_chip_wormhole_link_arbiter_if.slave     link
);
    localparam int sel_w_lp = $clog2(num_in_p);

    typedef enum logic {
        e_idle,
        e_locked
    } state_e;

    state_e                  r_state, w_state_nxt;
    logic [sel_w_lp-1:0]     r_last, w_last_nxt;
    logic [sel_w_lp-1:0]     r_owner, w_owner_nxt;
    logic [len_width_p-1:0]  r_cnt, w_cnt_nxt;

    logic [sel_w_lp-1:0]     w_rr_sel;
    logic [sel_w_lp-1:0]     w_sel;
    logic [num_in_p-1:0]     w_sel_oh;
    logic [flit_width_p-1:0] w_data;
    logic [len_width_p-1:0]  w_len;
    logic                    w_any_v;
    logic                    w_v_o;
    logic                    w_xfer;

    // Search starts one past the last packet's winner, so that source is served last.
    always_comb begin : rr_search
        logic                w_found;
        logic [sel_w_lp-1:0] w_idx;
        w_found  = 1'b0;
        w_rr_sel = '0;
        w_idx    = '0;
        for (int i = 1; i <= num_in_p; i++) begin
            w_idx = sel_w_lp'((int'(r_last) + i) % num_in_p);
            if (!w_found && link.v_i[w_idx]) begin
                w_found  = 1'b1;
                w_rr_sel = w_idx;
            end
        end
    end

    assign w_any_v  = |link.v_i;
    assign w_sel    = (r_state == e_locked) ? r_owner : w_rr_sel;
    assign w_sel_oh = num_in_p'(1) << w_sel;
    assign w_data   = link.data_i[w_sel*flit_width_p +: flit_width_p];
    assign w_len    = w_data[len_offset_p +: len_width_p];

    always_comb begin
        w_v_o        = 1'b0;
        link.grant_o = '0;
        link.busy_o  = 1'b0;
        if (!reset_i) begin
            if (r_state == e_locked) begin
                w_v_o        = link.v_i[r_owner];
                link.grant_o = w_sel_oh;
                link.busy_o  = 1'b1;
            end else begin
                w_v_o        = w_any_v;
                link.grant_o = w_any_v ? w_sel_oh : '0;
            end
        end
    end

    assign w_xfer      = w_v_o & link.ready_i;
    assign link.v_o    = w_v_o;
    assign link.data_o = w_data;
    assign link.yumi_o = w_xfer ? w_sel_oh : '0;

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        if (w_xfer) begin
            case (r_state)
                e_idle: begin
                    if (w_len == '0) begin
                        w_last_nxt = w_sel;
                    end else begin
                        w_state_nxt = e_locked;
                        w_owner_nxt = w_sel;
                        w_cnt_nxt   = w_len;
                    end
                end
                e_locked: begin
                    w_cnt_nxt = r_cnt - len_width_p'(1);
                    if (r_cnt == len_width_p'(1)) begin
                        w_state_nxt = e_idle;
                        w_last_nxt  = r_owner;
                        w_cnt_nxt   = '0;
                    end
                end
                default: w_state_nxt = e_idle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= e_idle;
            r_last  <= sel_w_lp'(num_in_p - 1);
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    a_yumi_onehot: assert property (@(posedge clk_i) disable iff (reset_i)
        $onehot0(link.yumi_o));
    a_yumi_has_valid: assert property (@(posedge clk_i) disable iff (reset_i)
        ((link.yumi_o & ~link.v_i) == '0));

endmodule

// File: tb/tb_bp_chip_wormhole_link_arbiter.sv
// Directed scenarios followed by random traffic, checked cycle by cycle against a
// packet-level model of the arbiter (owner, flits left in packet, priority pointer).
module tb_bp_chip_wormhole_link_arbiter;
    localparam int N  = 2;
    localparam int FW = 64;

    logic clk;
    logic reset;
    logic [FW-1:0] dat [N];

    int n_chk = 0;
    int n_err = 0;

    // Reference model: -1 owner means no packet in progress.
    int m_owner = -1;
    int m_left  = 0;
    int m_prio  = 0;

    logic       obs_v;
    logic [1:0] obs_grant;

    bp_chip_wormhole_link_arbiter_if #(.num_in_p(N), .flit_width_p(FW)) link ();

    bp_chip_wormhole_link_arbiter #(
        .num_in_p    (N),
        .flit_width_p(FW),
        .len_width_p (4),
        .len_offset_p(0)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .link   (link.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW-1:0] hdr(input int len);
        logic [FW-1:0] d;
        d       = {$urandom(), $urandom()};
        d[3:0]  = 4'(len);
        return d;
    endfunction

    // One clock: drive inputs already set, compare at negedge, advance model, pass posedge.
    task automatic step(input string tag);
        logic          e_v, e_busy, xfer;
        logic [1:0]    e_yumi, e_grant;
        logic [FW-1:0] e_dat;
        int            sel;
        link.data_i = {dat[1], dat[0]};
        @(negedge clk);
        e_v = 1'b0; e_busy = 1'b0; e_yumi = 2'b00; e_grant = 2'b00; sel = 0;
        if (!reset) begin
            if (m_owner >= 0) begin
                sel     = m_owner;
                e_v     = link.v_i[sel];
                e_grant = 2'(1 << sel);
                e_busy  = 1'b1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!e_v && link.v_i[(m_prio + k) % N]) begin
                        e_v = 1'b1;
                        sel = (m_prio + k) % N;
                    end
                end
                e_grant = e_v ? 2'(1 << sel) : 2'b00;
            end
        end
        xfer   = e_v & link.ready_i;
        e_yumi = xfer ? 2'(1 << sel) : 2'b00;
        e_dat  = dat[sel];

        obs_v     = link.v_o;
        obs_grant = link.grant_o;
        check({tag, ".v_o"},     64'(link.v_o),    64'(e_v));
        check({tag, ".yumi_o"},  64'(link.yumi_o), 64'(e_yumi));
        check({tag, ".grant_o"}, 64'(link.grant_o), 64'(e_grant));
        check({tag, ".busy_o"},  64'(link.busy_o), 64'(e_busy));
        if (e_v) check({tag, ".data_o"}, link.data_o, e_dat);

        if (reset) begin
            m_owner = -1; m_left = 0; m_prio = 0;
        end else if (xfer) begin
            if (m_owner >= 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_owner = -1;
                    m_prio  = (sel + 1) % N;
                end
            end else if (int'(e_dat[3:0]) == 0) begin
                m_prio = (sel + 1) % N;
            end else begin
                m_owner = sel;
                m_left  = int'(e_dat[3:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        link.v_i = '0;
        link.ready_i = 1'b1;
        dat[0] = '0; dat[1] = '0;
        link.data_i = '0;
        #1;
        step("rst0");
        step("rst1");

        // Only source 1 valid, single-flit packet, right out of reset.
        reset = 1'b0;
        link.v_i = 2'b10; dat[1] = hdr(0);
        step("single");
        check("single.grant_lit", 64'(obs_grant), 64'(2'b10));
        link.v_i = 2'b00;
        step("idle");

        // Both sources always valid with single-flit packets: strict alternation.
        link.v_i = 2'b11;
        for (int i = 0; i < 6; i++) begin
            dat[0] = hdr(0); dat[1] = hdr(0);
            step("rr");
            check("rr.grant_lit", 64'(obs_grant), (i % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
        end

        // Source 0 sends a 4-flit packet while source 1 waits.
        dat[0] = hdr(3); dat[1] = hdr(0);
        step("lock.hdr");
        for (int i = 0; i < 3; i++) begin
            dat[0] = {$urandom(), $urandom()};
            step("lock.body");
        end
        dat[0] = hdr(0);
        step("lock.after");
        check("lock.after_lit", 64'(obs_grant), 64'(2'b10));

        // Owner stalls mid-packet for two cycles.
        dat[0] = hdr(2);
        step("stall.hdr");
        link.v_i = 2'b10;
        step("stall.gap0");
        check("stall.v_lit", 64'(obs_v), 64'(0));
        step("stall.gap1");
        link.v_i = 2'b11;
        dat[0] = {$urandom(), $urandom()};
        step("stall.body0");
        dat[0] = {$urandom(), $urandom()};
        step("stall.body1");

        // Header held while downstream is not ready.
        link.v_i = 2'b01; dat[0] = hdr(1);
        link.ready_i = 1'b0;
        for (int i = 0; i < 5; i++) step("bp");
        link.ready_i = 1'b1;
        step("bp.hdr");
        dat[0] = {$urandom(), $urandom()};
        step("bp.body");

        // Maximum-length packet cut short by reset.
        dat[0] = hdr(15);
        step("max.hdr");
        for (int i = 0; i < 7; i++) begin
            dat[0] = {$urandom(), $urandom()};
            step("max.body");
        end
        reset = 1'b1;
        step("max.rst");
        reset = 1'b0;
        link.v_i = 2'b11; dat[0] = hdr(0); dat[1] = hdr(0);
        step("max.after");
        check("max.prio_lit", 64'(obs_grant), 64'(2'b01));

        // Full-length packet run to completion.
        link.v_i = 2'b11;
        dat[0] = hdr(0); dat[1] = hdr(15);
        step("full.hdr");
        for (int i = 0; i < 15; i++) begin
            dat[1] = {$urandom(), $urandom()};
            step("full.body");
        end
        dat[1] = hdr(0);
        step("full.after");

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            reset        = ($urandom_range(0, 199) == 0);
            link.ready_i = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                link.v_i[k] = ($urandom_range(0, 3) != 0);
                dat[k] = hdr(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 15)));
            end
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
